// File: rtl/noc_inject_scheduler_pkg.sv
// Noc_parameters: shared mesh NoC sizing and injection scheduler state type
package Noc_parameters;
   localparam int Noc_X_Size   = 2;
   localparam int Noc_Y_Size   = 2;
   localparam int Noc_Node_Num = Noc_X_Size * Noc_Y_Size;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE} noc_sched_state_e;
endpackage

// File: rtl/noc_inject_scheduler_if.sv
// noc_inject_scheduler_if: config, per-node handshake and status bundle of the injection scheduler
interface noc_inject_scheduler_if
   import Noc_parameters::*;
#(
   parameter int NODE_NUM = Noc_Node_Num,
   parameter int ROUND_W  = 8,
   parameter int GAP_W    = 8
);
   logic                        cfg_start;
   logic [ROUND_W-1:0]          cfg_rounds;
   logic [GAP_W-1:0]            cfg_gap;
   logic [NODE_NUM-1:0]         send_done;
   logic [NODE_NUM-1:0]         send_start;
   logic                        busy;
   logic                        done;
   logic [$clog2(NODE_NUM)-1:0] cur_node;
   logic                        timeout_err;
   modport master (output cfg_start, cfg_rounds, cfg_gap, send_done,
                   input  send_start, busy, done, cur_node, timeout_err);
   modport slave  (input  cfg_start, cfg_rounds, cfg_gap, send_done,
                   output send_start, busy, done, cur_node, timeout_err);
endinterface

// File: rtl/noc_inject_scheduler_timer.sv
// noc_sched_timer: loadable down-counter with a zero flag, holds at zero
module noc_sched_timer #(
   parameter int W = 8
) (
   input  logic         noc_clk,
   input  logic         noc_rst_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt_d, cnt_q;
   // load has priority over decrement; the count never wraps below zero
   always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   // counter register
   always_ff @(posedge noc_clk or negedge noc_rst_n)
      if (!noc_rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign zero = cnt_q == '0;
endmodule

// File: rtl/noc_inject_scheduler.sv
// noc_inject_scheduler: round-robin, handshake-paced per-node packet injection scheduler
// Optional WAIT timeout is built only when NOC_SCHED_TIMEOUT_EN is defined.
module noc_inject_scheduler
   import Noc_parameters::*;
#(
   parameter int NODE_NUM = Noc_Node_Num,
   parameter int ROUND_W  = 8,
   parameter int GAP_W    = 8,
   parameter int TIMEOUT  = 255
) (
   input logic                   noc_clk,
   input logic                   noc_rst_n,
   noc_inject_scheduler_if.slave bus
);
   localparam int PW = $clog2(NODE_NUM);
   noc_sched_state_e   state_d, state_q;
   logic [PW-1:0]      ptr_d, ptr_q;
   logic [ROUND_W-1:0] rounds_d, rounds_q;
   logic [GAP_W-1:0]   gap_d, gap_q;
   logic               hit, tmo, accept, last, adv, gap_zero;
   assign hit    = bus.send_done[ptr_q];
   assign last   = ptr_q == PW'(NODE_NUM - 1);
   assign accept = state_q == WAIT && (hit || tmo);
   assign adv    = (accept && gap_q == '0) || (state_q == GAP && gap_zero);
   // gap timer is loaded with gap-1 so the last GAP cycle is the one that sees zero
   noc_sched_timer #(.W(GAP_W)) u_gap (
      .noc_clk  (noc_clk),
      .noc_rst_n(noc_rst_n),
      .load     (accept && gap_q != '0),
      .dec      (state_q == GAP),
      .load_val (gap_q - 1'b1),
      .zero     (gap_zero)
   );
`ifdef NOC_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic err_d, err_q, tmo_zero;
   // reloaded on every ISSUE so each WAIT gets a full TIMEOUT-cycle budget
   noc_sched_timer #(.W(TW)) u_tmo (
      .noc_clk  (noc_clk),
      .noc_rst_n(noc_rst_n),
      .load     (state_q == ISSUE),
      .dec      (state_q == WAIT),
      .load_val (TW'(TIMEOUT - 1)),
      .zero     (tmo_zero)
   );
   assign tmo = state_q == WAIT && tmo_zero && !hit;
   // sticky error, cleared only when a new schedule is accepted
   always_comb err_d = (state_q == IDLE && bus.cfg_start) ? 1'b0 : err_q | tmo;
   // error flag register
   always_ff @(posedge noc_clk or negedge noc_rst_n)
      if (!noc_rst_n) err_q <= 1'b0;
      else err_q <= err_d;
   assign bus.timeout_err = err_q;
`else
   assign tmo             = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif
   // state and schedule registers
   always_ff @(posedge noc_clk or negedge noc_rst_n)
      if (!noc_rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         rounds_q <= '0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         rounds_q <= rounds_d;
         gap_q    <= gap_d;
      end
   // next state: config is latched only in IDLE; advancing overrides the per-state choice
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      rounds_d = rounds_q;
      gap_d    = gap_q;
      case (state_q)
         IDLE: if (bus.cfg_start) begin
            rounds_d = bus.cfg_rounds;
            gap_d    = bus.cfg_gap;
            ptr_d    = '0;
            state_d  = bus.cfg_rounds == '0 ? DONE : ISSUE;
         end
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = accept ? GAP : WAIT;
         DONE:    state_d = IDLE;
         default: state_d = state_q;
      endcase
      if (adv) begin
         ptr_d    = last ? '0 : ptr_q + 1'b1;
         rounds_d = last ? rounds_q - 1'b1 : rounds_q;
         state_d  = (last && rounds_q == ROUND_W'(1)) ? DONE : ISSUE;
      end
   end
   // outputs decoded purely from registered state
   always_comb begin
      bus.send_start = state_q == ISSUE ? {{(NODE_NUM-1){1'b0}}, 1'b1} << ptr_q : '0;
      bus.busy       = state_q == ISSUE || state_q == WAIT || state_q == GAP;
      bus.done       = state_q == DONE;
      bus.cur_node   = ptr_q;
   end
endmodule

// File: tb/tb_noc_inject_scheduler.sv
// tb_noc_inject_scheduler: table, randomized and corner-case checks against a schedule-level timing model
module tb_noc_inject_scheduler;
   import Noc_parameters::*;
   localparam int NN = 4;
`ifdef NOC_SCHED_TIMEOUT_EN
   localparam int TMO = 10;
`else
   localparam int TMO = 255;
`endif
   typedef struct {int rounds; int gap; int lat; bit intrude; int exp_np; int exp_d;} vec_t;
   logic noc_clk   = 1'b0;
   logic noc_rst_n = 1'b0;
   int   checks = 0, errors = 0;
   int   lat_q[$];
   int   exp_c[$];
   int   exp_n[$];
   int   exp_d;
   noc_inject_scheduler_if #(.NODE_NUM(NN)) bus ();
   noc_inject_scheduler #(.NODE_NUM(NN), .TIMEOUT(TMO)) dut (
      .noc_clk  (noc_clk),
      .noc_rst_n(noc_rst_n),
      .bus      (bus)
   );
   always #5 noc_clk = ~noc_clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // each issue costs 1 + latency (or TMO if the node never answers) + gap; done one cycle after the last
   function automatic void model(input int rounds, input int gap);
      int t = 1, k = 0, l;
      exp_c.delete();
      exp_n.delete();
      for (int r = 0; r < rounds; r++)
         for (int n = 0; n < NN; n++) begin
            l = (k < lat_q.size()) ? lat_q[k] : 1;
            if (l < 0) l = TMO;
            k++;
            exp_c.push_back(t);
            exp_n.push_back(n);
            t = t + 1 + l + gap;
         end
      exp_d = t;
   endfunction

   task automatic fill_lat(input int n, input int lat);
      lat_q.delete();
      for (int i = 0; i < n; i++) lat_q.push_back(lat < 0 ? $urandom_range(1, 4) : lat);
   endtask

   task automatic run(input int rounds, input int gap, input bit intrude, output int np, output int dcyc);
      int pc[$], pn[$], due[$], dn[$];
      int bad_busy = 0, bad_hot = 0, node, l, ones;
      logic [NN-1:0] sd;
      model(rounds, gap);
      @(negedge noc_clk);
      bus.cfg_start = 1'b1; bus.cfg_rounds = 8'(rounds); bus.cfg_gap = 8'(gap);
      @(negedge noc_clk);
      bus.cfg_start = 1'b0; bus.cfg_rounds = 8'($urandom); bus.cfg_gap = 8'($urandom);
      dcyc = -1;
      for (int c = 1; c <= 2000 && dcyc < 0; c++) begin
         if (bus.send_start != '0) begin
            ones = 0; node = 0;
            for (int j = 0; j < NN; j++) if (bus.send_start[j]) begin ones++; node = j; end
            if (ones != 1 || node != int'(bus.cur_node)) bad_hot++;
            pc.push_back(c);
            pn.push_back(node);
            l = (pc.size() <= lat_q.size()) ? lat_q[pc.size()-1] : 1;
            if (l > 0) begin due.push_back(c + l); dn.push_back(node); end
         end
         if (bus.done) dcyc = c;
         if (bus.busy !== (rounds != 0 && c < exp_d)) bad_busy++;
         sd = '0;
         foreach (due[i]) if (due[i] == c) sd[dn[i]] = 1'b1;
         bus.cfg_start = intrude && c == 2;
         if (intrude && c == 2) begin bus.cfg_rounds = 8'd5; sd[2] = 1'b1; end
         bus.send_done = sd;
         @(negedge noc_clk);
      end
      bus.cfg_start = 1'b0;
      bus.send_done = '0;
      np = pc.size();
      chk("pulse_count", np, exp_c.size());
      for (int i = 0; i < np && i < exp_c.size(); i++) begin
         chk("pulse_cycle", pc[i], exp_c[i]);
         chk("pulse_node", pn[i], exp_n[i]);
      end
      chk("done_cycle", dcyc, exp_d);
      chk("busy_profile", bad_busy, 0);
      chk("onehot_cur_node", bad_hot, 0);
      chk("done_single", bus.done, 0);
   endtask

   initial begin
      vec_t tbl[6];
      int np, dc, act;
      tbl[0] = '{1, 0, 3, 1'b0, 4, 17};
      tbl[1] = '{2, 2, 1, 1'b0, 8, 33};
      tbl[2] = '{0, 0, 1, 1'b0, 0, 1};
      tbl[3] = '{1, 0, 3, 1'b1, 4, 17};
      tbl[4] = '{3, 0, 1, 1'b0, 12, 25};
      tbl[5] = '{1, 1, 2, 1'b0, 4, 17};
      bus.cfg_start = 1'b0; bus.cfg_rounds = '0; bus.cfg_gap = '0; bus.send_done = '0;
      #12;
      chk("rst_send_start", bus.send_start, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_cur_node", bus.cur_node, 0);
      chk("rst_timeout_err", bus.timeout_err, 0);
      @(negedge noc_clk);
      noc_rst_n = 1'b1;
      foreach (tbl[i]) begin
         fill_lat(tbl[i].rounds * NN, tbl[i].lat);
         run(tbl[i].rounds, tbl[i].gap, tbl[i].intrude, np, dc);
         chk("tbl_pulses", np, tbl[i].exp_np);
         chk("tbl_done", dc, tbl[i].exp_d);
      end
      chk("no_timeout_err", bus.timeout_err, 0);
      for (int k = 0; k < 6; k++) begin
         int r = $urandom_range(0, 3), g = $urandom_range(0, 3);
         fill_lat(r * NN, -1);
         run(r, g, 1'b0, np, dc);
      end
`ifdef NOC_SCHED_TIMEOUT_EN
      lat_q.delete();
      lat_q = '{2, -1, 2, 2};
      run(1, 1, 1'b0, np, dc);
      chk("timeout_flag_set", bus.timeout_err, 1);
      fill_lat(0, 1);
      run(0, 0, 1'b0, np, dc);
      chk("timeout_flag_clear", bus.timeout_err, 0);
`endif
      @(negedge noc_clk);
      bus.cfg_start = 1'b1; bus.cfg_rounds = 8'd1; bus.cfg_gap = 8'd0;
      @(negedge noc_clk);
      bus.cfg_start = 1'b0;
      for (int c = 1; c < 10; c++) begin
         bus.send_done = (c == 4) ? 4'b0001 : (c == 8) ? 4'b0010 : 4'b0000;
         @(negedge noc_clk);
      end
      bus.send_done = '0;
      chk("pre_rst_cur_node", bus.cur_node, 2);
      chk("pre_rst_busy", bus.busy, 1);
      #2 noc_rst_n = 1'b0;
      #1;
      chk("mid_rst_send_start", bus.send_start, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_cur_node", bus.cur_node, 0);
      chk("mid_rst_timeout_err", bus.timeout_err, 0);
      @(negedge noc_clk);
      noc_rst_n = 1'b1;
      act = 0;
      repeat (12) begin
         @(negedge noc_clk);
         if (bus.send_start != '0 || bus.busy || bus.done || bus.cur_node != '0) act++;
      end
      chk("post_rst_idle", act, 0);
      fill_lat(NN, 2);
      run(1, 0, 1'b0, np, dc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
